// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg
//   Shared definitions for the EX-stage multiply sequencer.
//   - alu_ctrl_t : ALU control codes, shared with the ALU control decode and the ALU.
//   - mul_state_t: sequencer FSM states.
//   - is_mul()   : true when an ALU control code selects the multiply operation.
package mul_sequencer_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SLL = 4'd3,
        ALU_SRL = 4'd4,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_MUL = 4'd8
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } mul_state_t;

    function automatic logic is_mul(input logic [3:0] ctrl);
        return ctrl == ALU_MUL;
    endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if
//   EX-stage side of the multiply sequencer.
//   master: EX stage drives ex_valid, alu_control, flush, op_a, op_b and
//           receives stall, mul_done, mul_result.
//   slave : the sequencer, mirror image of master.
interface mul_sequencer_if #(
    parameter int DATA_W = 32
) ();

    logic              ex_valid;
    logic [3:0]        alu_control;
    logic              flush;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              stall;
    logic              mul_done;
    logic [DATA_W-1:0] mul_result;

    modport master (
        output ex_valid, alu_control, flush, op_a, op_b,
        input  stall, mul_done, mul_result
    );

    modport slave (
        input  ex_valid, alu_control, flush, op_a, op_b,
        output stall, mul_done, mul_result
    );

endinterface

// File: rtl/mul_shift_add.sv
// mul_shift_add
//   Datapath of the radix-2 shift-add multiplier: multiplicand, multiplier
//   and accumulator registers, one add-and-shift step per enabled cycle.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     load      : capture op_a/op_b, clear the accumulator
//     step      : perform one add-shift iteration
//     op_a, op_b: multiplicand / multiplier
//     acc_next  : accumulator value after the current iteration (mod 2^DATA_W)
module mul_shift_add #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] acc_next
);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;

    // Add the shifted multiplicand when the current multiplier LSB is set.
    // Truncation to DATA_W bits gives the low product word for signed and
    // unsigned operands alike.
    always_comb begin
        acc_next = mplier[0] ? acc + mcand : acc;
    end

    // Operand/accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer
//   Multi-cycle multiply sequencer for the EX stage. A valid EX instruction
//   with ALU control MUL starts a DATA_W-iteration shift-add multiply; the
//   pipeline is stalled meanwhile, then the low product word is presented
//   with mul_done for one cycle while the pipeline is released.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     bus      : slave side of mul_sequencer_if
//                in : ex_valid, alu_control, flush, op_a, op_b
//                out: stall (comb), mul_done (state decode), mul_result (reg)
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mul_sequencer_if.slave     bus
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    mul_state_t        state;
    mul_state_t        next_state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] acc_next;
    logic              start;
    logic              last_iter;
    logic              load;
    logic              step;

    assign start     = bus.ex_valid & is_mul(bus.alu_control) & ~bus.flush;
    assign last_iter = (count == CNT_W'(DATA_W - 1));
    assign load      = (state == ST_IDLE) & start;
    // A flush freezes the datapath; the FSM abandons the operation anyway.
    assign step      = (state == ST_RUN) & ~bus.flush;

    mul_shift_add #(.DATA_W(DATA_W)) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .op_a     (bus.op_a),
        .op_b     (bus.op_b),
        .acc_next (acc_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. DONE always returns to IDLE: the MUL still sitting
    // in EX during DONE must not retrigger a second multiply.
    always_comb begin
        next_state = state;
        if (bus.flush) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) next_state = ST_RUN;
                ST_RUN:  if (last_iter) next_state = ST_DONE;
                ST_DONE: next_state = ST_IDLE;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Output logic. stall covers the start cycle plus all RUN cycles and is
    // dropped on flush and reset so squashed or aborted work never holds
    // the pipeline.
    always_comb begin
        bus.stall    = 1'b0;
        bus.mul_done = (state == ST_DONE);
        if (!rst && !bus.flush) begin
            bus.stall = ((state == ST_IDLE) & start) | (state == ST_RUN);
        end
    end

    // Iteration counter and result register. The result is captured from
    // the final iteration so it is already valid during DONE, and it holds
    // until the next completed multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            result_q <= '0;
        end else begin
            if (load) begin
                count <= '0;
            end else if (step) begin
                count <= count + 1'b1;
            end
            if (step && last_iter) begin
                result_q <= acc_next;
            end
        end
    end

    assign bus.mul_result = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer
//   Self-checking bench for mul_sequencer. A cycle-level reference model
//   tracks the age of the current multiply and computes the product with
//   plain arithmetic; every cycle stall, mul_done and mul_result are
//   compared, and directed scenarios add latency/result checks.
module tb_mul_sequencer;
    import mul_sequencer_pkg::*;

    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mul_sequencer_if #(.DATA_W(DATA_W)) bus ();

    mul_sequencer #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          age = -1;
    bit          check_en = 1'b0;
    logic [31:0] pend = '0;
    logic [31:0] last_result = '0;
    int          stall_seen = 0;
    int          done_cycles[$];
    logic [31:0] done_vals[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs,
    // then advance the reference model to the next cycle.
    task automatic applyStimulus(input logic r, input logic ev, input logic [3:0] ac,
                                 input logic fl, input logic [31:0] a, input logic [31:0] b);
        logic        start;
        logic        exp_stall;
        logic        exp_done;
        logic [63:0] prod;
        @(negedge clk);
        rst             = r;
        bus.ex_valid    = ev;
        bus.alu_control = ac;
        bus.flush       = fl;
        bus.op_a        = a;
        bus.op_b        = b;
        #1;
        start    = ev && (ac == 4'd8) && !fl;
        exp_done = (age == DATA_W + 1);
        if (r || fl)      exp_stall = 1'b0;
        else if (age < 0) exp_stall = start;
        else              exp_stall = (age <= DATA_W);
        if (check_en) begin
            checkOutput("stall", {31'b0, bus.stall}, {31'b0, exp_stall});
            checkOutput("mul_done", {31'b0, bus.mul_done}, {31'b0, exp_done});
            checkOutput("mul_result", bus.mul_result, last_result);
        end
        if (bus.mul_done === 1'b1) begin
            done_cycles.push_back(cyc);
            done_vals.push_back(bus.mul_result);
        end
        if (bus.stall === 1'b1) stall_seen++;
        if (r) begin
            age         = -1;
            last_result = '0;
            check_en    = 1'b1;
        end else if (fl) begin
            age = -1;
        end else if (age < 0) begin
            if (start) begin
                age  = 1;
                prod = {32'b0, a} * {32'b0, b};
                pend = prod[31:0];
            end
        end else if (age < DATA_W) begin
            age++;
        end else if (age == DATA_W) begin
            age++;
            last_result = pend;
        end else begin
            age = -1;
        end
        cyc++;
    endtask

    // Start a MUL and keep it in EX through DONE with scrambled operands.
    task automatic runMul(input logic [31:0] a, input logic [31:0] b, output int start_cyc);
        start_cyc = cyc;
        applyStimulus(1'b0, 1'b1, 4'd8, 1'b0, a, b);
        repeat (DATA_W + 1) applyStimulus(1'b0, 1'b1, 4'd8, 1'b0, $urandom, $urandom);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, $urandom, $urandom);
    endtask

    task automatic clearLog();
        done_cycles.delete();
        done_vals.delete();
        stall_seen = 0;
    endtask

    initial begin
        int s0;
        int s1;
        int k;

        // Reset with a MUL start held on the inputs.
        $display("[TB] reset");
        repeat (2) applyStimulus(1'b1, 1'b1, 4'd8, 1'b0, 32'd3, 32'd5);
        clearLog();
        idleCycle();
        checkOutput("idle_after_reset_done", done_cycles.size(), 0);

        // 3 x 5 with exact latency.
        $display("[TB] 3 x 5");
        clearLog();
        runMul(32'd3, 32'd5, s0);
        checkOutput("stall_cycles_3x5", stall_seen, DATA_W + 1);
        checkOutput("done_count_3x5", done_cycles.size(), 1);
        if (done_cycles.size() == 1) begin
            checkOutput("done_latency_3x5", done_cycles[0] - s0, DATA_W + 1);
            checkOutput("result_3x5", done_vals[0], 32'd15);
        end
        idleCycle();

        // Wrap and sign cases.
        $display("[TB] wrap and sign");
        clearLog();
        runMul(32'hFFFF_FFFF, 32'hFFFF_FFFF, s0);
        idleCycle();
        runMul(32'hFFFF_FFF9, 32'd6, s1);
        idleCycle();
        checkOutput("done_count_wrap", done_cycles.size(), 2);
        if (done_cycles.size() == 2) begin
            checkOutput("result_ffff_sq", done_vals[0], 32'h0000_0001);
            checkOutput("result_neg7x6", done_vals[1], 32'hFFFF_FFD6);
        end

        // Flush at the 10th RUN cycle, then 7 x 7.
        $display("[TB] flush mid-run");
        clearLog();
        applyStimulus(1'b0, 1'b1, 4'd8, 1'b0, 32'd123, 32'd456);
        repeat (9) applyStimulus(1'b0, 1'b1, 4'd8, 1'b0, $urandom, $urandom);
        applyStimulus(1'b0, 1'b1, 4'd8, 1'b1, $urandom, $urandom);
        repeat (3) idleCycle();
        checkOutput("flush_no_done", done_cycles.size(), 0);
        runMul(32'd7, 32'd7, s0);
        idleCycle();
        checkOutput("done_count_7x7", done_cycles.size(), 1);
        if (done_cycles.size() == 1) begin
            checkOutput("done_latency_7x7", done_cycles[0] - s0, DATA_W + 1);
            checkOutput("result_7x7", done_vals[0], 32'd49);
        end

        // Reset at the 5th RUN cycle, then back-to-back 2x3 and 4x5.
        $display("[TB] reset mid-run and back-to-back");
        clearLog();
        applyStimulus(1'b0, 1'b1, 4'd8, 1'b0, 32'd99, 32'd77);
        repeat (4) applyStimulus(1'b0, 1'b1, 4'd8, 1'b0, $urandom, $urandom);
        applyStimulus(1'b1, 1'b1, 4'd8, 1'b0, $urandom, $urandom);
        runMul(32'd2, 32'd3, s0);
        runMul(32'd4, 32'd5, s1);
        idleCycle();
        checkOutput("done_count_b2b", done_cycles.size(), 2);
        if (done_cycles.size() == 2) begin
            checkOutput("b2b_first_latency", done_cycles[0] - s0, DATA_W + 1);
            checkOutput("b2b_spacing", done_cycles[1] - done_cycles[0], DATA_W + 2);
            checkOutput("result_2x3", done_vals[0], 32'd6);
            checkOutput("result_4x5", done_vals[1], 32'd20);
        end

        // Non-MUL instructions never stall.
        $display("[TB] non-mul");
        clearLog();
        repeat (10) applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, $urandom, $urandom);
        repeat (10) applyStimulus(1'b0, 1'b0, 4'd8, 1'b0, $urandom, $urandom);
        checkOutput("nonmul_stall", stall_seen, 0);
        checkOutput("nonmul_done", done_cycles.size(), 0);

        // Random operands, gaps and occasional mid-run flushes.
        $display("[TB] random");
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, DATA_W);
                applyStimulus(1'b0, 1'b1, 4'd8, 1'b0, $urandom, $urandom);
                repeat (k - 1) applyStimulus(1'b0, 1'b1, 4'd8, 1'b0, $urandom, $urandom);
                applyStimulus(1'b0, 1'b1, 4'd8, 1'b1, $urandom, $urandom);
            end else begin
                runMul($urandom, $urandom, s0);
            end
            repeat ($urandom_range(0, 2)) idleCycle();
        end
        idleCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle multiply sequencer for the EX stage. When the ALU control decode selects the multiply operation (code 4'd8) for a valid EX instruction, this block takes the operands, runs a radix-2 shift-add multiply over DATA_W cycles, and stalls the pipeline. It then presents the low DATA_W bits of the product for one cycle, when the pipeline is released. It sits beside the ALU; the EX result mux selects `mul_result` when `mul_done` is high.

## Interface
- DATA_W, 32: operand/result width; also the iteration count.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ex_valid  in  1  EX stage holds a valid instruction.
- alu_control  in  4  ALU control code from ALU control decode; 4'd8 = multiply.
- flush  in  1  squash EX instruction (branch/exception).
- op_a  in  DATA_W  multiplicand.
- op_b  in  DATA_W  multiplier.
- stall  out  1  hold IF/ID/EX pipeline registers (combinational).
- mul_done  out  1  product valid this cycle (registered state decode).
- mul_result  out  DATA_W  product, low DATA_W bits (registered).

## Operation
- start = ex_valid & (alu_control == 4'd8) & !flush.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start, latch mcand=op_a, mplier=op_b, acc=0, count=0, and go to RUN.
  - Otherwise stay in IDLE.
- RUN, per cycle:
  - If mplier[0], acc = acc + mcand (mod 2^DATA_W).
  - Then mcand <<= 1, mplier >>= 1, count++.
  - When count == DATA_W-1 is being processed, go to DONE.
  - There is no early exit, so latency is fixed.
- DONE: mul_done=1 and mul_result=acc; next state IDLE unconditionally. start is ignored in DONE, because the same MUL is still visible in EX.
- stall = !flush & ((IDLE & start) | RUN). stall is 0 in DONE, so the MUL leaves EX at the end of the DONE cycle.
- flush in any state:
  - Next state is IDLE.
  - mul_done does not assert for the squashed operation.
  - stall is 0 in the flush cycle.
- Arithmetic: unsigned shift-add truncated to DATA_W bits. This equals the RISC-V MUL low word for signed and unsigned operands; no sign handling is needed.
- mul_result holds its last value until the next DONE.
- Reset:
  - state=IDLE, acc=0, count=0, mcand=0, mplier=0.
  - stall=0, mul_done=0, mul_result=0.
  - Reset mid-RUN aborts the operation with no done pulse.

## Timing
- start seen in cycle T (IDLE): stall=1 in cycles T through T+DATA_W, RUN in T+1 through T+DATA_W.
- DONE, with mul_done=1, in T+DATA_W+1. The MUL occupies EX for DATA_W+2 cycles.
- Back-to-back MULs: the second MUL enters EX at T+DATA_W+2, finds IDLE, and starts immediately, with no bubble cycle.
- A non-MUL instruction (e.g. alu_control=4'd2 ADD) never raises stall.
- stall is a combinational function of state, ex_valid, alu_control and flush; there is no path from op_a/op_b to stall.

## Structure
- Shared package holds:
  - ALU control codes: AND=0, OR=1, ADD=2, SLL=3, SRL=4, SUB=6, SLT=7, MUL=8. These are shared with the ALU control decode and the ALU.
  - The state enum (IDLE/RUN/DONE).
- One sub-module is natural: mul_shift_add, the mcand/mplier/acc registers and one add-shift step per enable. mul_sequencer keeps the FSM, the counter (width $clog2(DATA_W)) and the stall/done logic.

## Test plan
- Reset: assert rst for 2 cycles with start held high -> stall=0, mul_done=0, mul_result=0, state IDLE after release.
- 3 × 5, DATA_W=32, start at T -> stall high T..T+32, mul_done only at T+33, mul_result=15.
- Wrap and sign cases:
  - 0xFFFFFFFF × 0xFFFFFFFF -> mul_result=0x00000001.
  - 0xFFFFFFF9 × 6 -> 0xFFFFFFD6.
- flush at the 10th RUN cycle -> stall=0 that cycle, IDLE next, no mul_done. A following MUL 7×7 -> 49 with full latency.
- rst at the 5th RUN cycle -> IDLE, no mul_done. Then back-to-back MULs 2×3 and 4×5 -> done pulses 34 cycles apart, results 6 then 20.
- ex_valid=1 with alu_control=2 (ADD), and ex_valid=0 with alu_control=8 -> stall never asserts, mul_done stays 0.
